// File: rtl/mult_seq_ctrl.sv
// Multi-cycle MULT/MULTU sequencer: 32x32->64 shift-add multiply that time-shares
// one external adder for operand negation, partial-product accumulation and result negation.
module mult_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_c,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    NEGA  = 3'd1,
    NEGB  = 3'd2,
    MUL   = 3'd3,
    NEGLO = 3'd4,
    NEGHI = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             nb_r;
  logic             nr_r;
  logic             carry_r;
  logic [CNT_W-1:0] cnt_r;
  logic             na_s;
  logic             nb_s;

  assign na_s = is_signed & a[WIDTH-1];
  assign nb_s = is_signed & b[WIDTH-1];

  // Adder operand select; decoded only from registered state so add_sum has no loop back.
  always_comb begin
    add_a   = {WIDTH{1'b0}};
    add_b   = {WIDTH{1'b0}};
    add_cin = 1'b0;
    case (state_r)
      NEGA: begin
        add_a   = ~a_r;
        add_cin = 1'b1;
      end
      NEGB: begin
        add_a   = ~b_r;
        add_cin = 1'b1;
      end
      MUL: begin
        if (lo[0]) begin
          add_a = hi;
          add_b = a_r;
        end else begin
          add_a = {WIDTH{1'b0}};
          add_b = {WIDTH{1'b0}};
        end
      end
      NEGLO: begin
        add_a   = ~lo;
        add_cin = 1'b1;
      end
      NEGHI: begin
        add_a   = ~hi;
        add_cin = carry_r;
      end
      default: begin
        add_a   = {WIDTH{1'b0}};
        add_b   = {WIDTH{1'b0}};
        add_cin = 1'b0;
      end
    endcase
  end

  // Sequencer state, operand/product registers and registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      nb_r    <= 1'b0;
      nr_r    <= 1'b0;
      carry_r <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
      hi      <= {WIDTH{1'b0}};
      lo      <= {WIDTH{1'b0}};
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            nb_r  <= nb_s;
            nr_r  <= na_s ^ nb_s;
            hi    <= {WIDTH{1'b0}};
            cnt_r <= {CNT_W{1'b0}};
            busy  <= 1'b1;
            if (na_s) begin
              state_r <= NEGA;
            end else if (nb_s) begin
              state_r <= NEGB;
            end else begin
              state_r <= MUL;
              lo      <= b;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        NEGA: begin
          a_r <= add_sum;
          if (nb_r) begin
            state_r <= NEGB;
          end else begin
            state_r <= MUL;
            lo      <= b_r;
          end
        end
        NEGB: begin
          b_r     <= add_sum;
          lo      <= add_sum;
          state_r <= MUL;
        end
        MUL: begin
          // One multiplier bit per cycle: the sum (or plain hi) shifts down into lo.
          if (lo[0]) begin
            hi <= {add_c, add_sum[WIDTH-1:1]};
            lo <= {add_sum[0], lo[WIDTH-1:1]};
          end else begin
            hi <= {1'b0, hi[WIDTH-1:1]};
            lo <= {hi[0], lo[WIDTH-1:1]};
          end
          cnt_r <= cnt_r + CNT_W'(1);
          if (cnt_r == CNT_LAST) begin
            if (nr_r) begin
              state_r <= NEGLO;
            end else begin
              state_r <= DONE;
              done    <= 1'b1;
            end
          end
        end
        NEGLO: begin
          lo      <= add_sum;
          carry_r <= add_c;
          state_r <= NEGHI;
        end
        NEGHI: begin
          hi      <= add_sum;
          state_r <= DONE;
          done    <= 1'b1;
        end
        DONE: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
